// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM read-side controller.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } rd_state_t;

    localparam int RD_LAT_MAX = 4;
    localparam int RD_CNT_W   = 3;

    // An out-of-range latency is a configuration error; clamping keeps the
    // counter load in range so the FSM can never stall in WAIT.
    function automatic int clamp_rd_lat(input int lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > RD_LAT_MAX) begin
            return RD_LAT_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/ram_read_ctrl.sv
// Read controller for two RAM banks: latch request, pulse one bank enable, wait RD_LAT, return word.
// Optional strobe-while-busy sticky flag: define RAM_READ_CTRL_OVERRUN_EN.
module ram_read_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_strobe,
    input  logic              ram_sel,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en_1,
    output logic              ram_rd_en_2,
    input  logic [DATA_W-1:0] ram_dout_1,
    input  logic [DATA_W-1:0] ram_dout_2,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
`ifdef RAM_READ_CTRL_OVERRUN_EN
    input  logic              overrun_clr,
    output logic              overrun,
`endif
    output logic              busy
);

    localparam logic [RD_CNT_W-1:0] RD_LAT_LD = RD_CNT_W'(clamp_rd_lat(RD_LAT));

    rd_state_t             state_reg, state_next;
    logic [ADDR_W-1:0]     addr_reg, addr_next;
    logic                  sel_reg, sel_next;
    logic [RD_CNT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]            rd_en_reg, rd_en_next;
    logic [DATA_W-1:0]     rd_data_reg, rd_data_next;
    logic                  rd_valid_reg, rd_valid_next;
    logic                  busy_reg, busy_next;

    logic                  accept;
    logic [1:0]            bank_hit;
    logic [DATA_W-1:0]     bank_dout [2];

    assign accept       = (state_reg == IDLE) && read_strobe;
    assign bank_dout[0] = ram_dout_1;
    assign bank_dout[1] = ram_dout_2;

    // Enable for bank gi is raised only when the accepted request selects it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_hit[gi] = accept && (int'(ram_sel) == gi);
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        sel_next      = sel_reg;
        cnt_next      = cnt_reg;
        rd_en_next    = 2'b00;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (read_strobe) begin
                    addr_next  = addr;
                    sel_next   = ram_sel;
                    rd_en_next = bank_hit;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = RD_LAT_LD;
                state_next = WAIT;
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg <= RD_CNT_W'(1)) begin
                    cnt_next      = '0;
                    rd_data_next  = bank_dout[sel_reg];
                    rd_valid_next = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            sel_reg      <= 1'b0;
            cnt_reg      <= '0;
            rd_en_reg    <= 2'b00;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            sel_reg      <= sel_next;
            cnt_reg      <= cnt_next;
            rd_en_reg    <= rd_en_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
            busy_reg     <= busy_next;
        end
    end

`ifdef RAM_READ_CTRL_OVERRUN_EN
    logic overrun_reg;

    // Set has priority so a collision in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_reg <= 1'b0;
        end else if (read_strobe && busy_reg) begin
            overrun_reg <= 1'b1;
        end else if (overrun_clr) begin
            overrun_reg <= 1'b0;
        end
    end

    assign overrun = overrun_reg;
`endif

    assign ram_addr    = addr_reg;
    assign ram_rd_en_1 = rd_en_reg[0];
    assign ram_rd_en_2 = rd_en_reg[1];
    assign rd_data     = rd_data_reg;
    assign rd_valid    = rd_valid_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_ram_read_ctrl.sv
// Directed bench for ram_read_ctrl: instance a uses RD_LAT=1, instance b uses RD_LAT=3.
// Overrun checks are compiled only with RAM_READ_CTRL_OVERRUN_EN.
module tb_ram_read_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       read_strobe = 1'b0;
    logic       ram_sel = 1'b0;
    logic [7:0] addr = 8'h00;

    logic [7:0] a_ram_addr, b_ram_addr;
    logic       a_en1, a_en2, b_en1, b_en2;
    logic [7:0] a_dout1 = 8'h00, a_dout2 = 8'h00, b_dout1 = 8'h00, b_dout2 = 8'h00;
    logic [7:0] a_rd_data, b_rd_data;
    logic       a_rd_valid, b_rd_valid, a_busy, b_busy;
`ifdef RAM_READ_CTRL_OVERRUN_EN
    logic       overrun_clr = 1'b0;
    logic       a_overrun, b_overrun;
`endif

    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];

    int vectors = 0;
    int errors  = 0;
    int en1_cnt_a = 0, en2_cnt_a = 0, valid_cnt_b = 0;

    always #5 clk = ~clk;

    ram_read_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .read_strobe(read_strobe), .ram_sel(ram_sel), .addr(addr),
        .ram_addr(a_ram_addr), .ram_rd_en_1(a_en1), .ram_rd_en_2(a_en2),
        .ram_dout_1(a_dout1), .ram_dout_2(a_dout2), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
`ifdef RAM_READ_CTRL_OVERRUN_EN
        .overrun_clr(overrun_clr), .overrun(a_overrun),
`endif
        .busy(a_busy)
    );

    ram_read_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .read_strobe(read_strobe), .ram_sel(ram_sel), .addr(addr),
        .ram_addr(b_ram_addr), .ram_rd_en_1(b_en1), .ram_rd_en_2(b_en2),
        .ram_dout_1(b_dout1), .ram_dout_2(b_dout2), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
`ifdef RAM_READ_CTRL_OVERRUN_EN
        .overrun_clr(overrun_clr), .overrun(b_overrun),
`endif
        .busy(b_busy)
    );

    // Bank models: the word addressed during the enable cycle appears after that edge and holds.
    always @(posedge clk) begin
        if (a_en1) a_dout1 <= mem1[a_ram_addr];
        if (a_en2) a_dout2 <= mem2[a_ram_addr];
        if (b_en1) b_dout1 <= mem1[b_ram_addr];
        if (b_en2) b_dout2 <= mem2[b_ram_addr];
        if (a_en1) en1_cnt_a <= en1_cnt_a + 1;
        if (a_en2) en2_cnt_a <= en2_cnt_a + 1;
        if (b_rd_valid) valid_cnt_b <= valid_cnt_b + 1;
        if (a_rd_valid) $display("txn a: rd_data=%02h", a_rd_data);
        if (b_rd_valid) $display("txn b: rd_data=%02h", b_rd_data);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int en1_base, en2_base, vb_base;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 8'(i) ^ 8'h66;
            mem2[i] = 8'(i) + 8'h6D;
        end
        mem1[8'h3A] = 8'h5C;
        mem2[8'h91] = 8'hA7;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ram_addr", a_ram_addr, 8'h00);
        check_val("rst_en", {a_en1, a_en2}, 2'b00);
        check_val("rst_rd_data", a_rd_data, 8'h00);
        check_val("rst_valid_busy", {a_rd_valid, a_busy}, 2'b00);
`ifdef RAM_READ_CTRL_OVERRUN_EN
        check_val("rst_overrun", a_overrun, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // Single read, bank 1, RD_LAT=1
        en2_base = en2_cnt_a;
        en1_base = en1_cnt_a;
        read_strobe = 1'b1; addr = 8'h3A; ram_sel = 1'b0;
        tick();
        read_strobe = 1'b0; addr = 8'hFF;
        check_val("s1_en1", a_en1, 1'b1);
        check_val("s1_en2", a_en2, 1'b0);
        check_val("s1_ram_addr", a_ram_addr, 8'h3A);
        check_val("s1_busy", a_busy, 1'b1);
        tick();
        check_val("s1_en1_off", a_en1, 1'b0);
        check_val("s1_valid_early", a_rd_valid, 1'b0);
        tick();
        check_val("s1_valid", a_rd_valid, 1'b1);
        check_val("s1_data", a_rd_data, 8'h5C);
        check_val("s1_busy_done", a_busy, 1'b0);
        tick();
        check_val("s1_valid_pulse", a_rd_valid, 1'b0);
        check_val("s1_data_hold", a_rd_data, 8'h5C);
        check_val("s1_addr_hold", a_ram_addr, 8'h3A);
        check_val("s1_en1_count", en1_cnt_a - en1_base, 1);
        check_val("s1_en2_never", en2_cnt_a - en2_base, 0);
        repeat (3) tick();

        // Latency sweep, bank 2, RD_LAT=3 on instance b
        read_strobe = 1'b1; addr = 8'h91; ram_sel = 1'b1;
        tick();
        read_strobe = 1'b0;
        check_val("lat3_en2", {b_en1, b_en2}, 2'b01);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_val($sformatf("lat3_valid_c%0d", k), b_rd_valid, (k == 4) ? 1'b1 : 1'b0);
        end
        check_val("lat3_data", b_rd_data, 8'hA7);
        tick();
        check_val("lat3_valid_pulse", b_rd_valid, 1'b0);
        repeat (2) tick();

        // Busy collision: strobes for 6 cycles on instance a -> reads at cycles 0 and 3
        en1_base = en1_cnt_a;
        ram_sel = 1'b0;
        for (int k = 0; k < 6; k++) begin
            read_strobe = 1'b1; addr = 8'h10 + 8'(k);
            tick();
            check_val($sformatf("col_en1_c%0d", k), a_en1, (k == 0 || k == 3) ? 1'b1 : 1'b0);
            if (k == 0 || k == 3)
                check_val($sformatf("col_addr_c%0d", k), a_ram_addr, 8'h10 + 8'(k));
`ifdef RAM_READ_CTRL_OVERRUN_EN
            if (k <= 1)
                check_val($sformatf("col_overrun_c%0d", k), a_overrun, (k == 1) ? 1'b1 : 1'b0);
`endif
        end
        read_strobe = 1'b0;
        repeat (2) tick();
        check_val("col_reads", en1_cnt_a - en1_base, 2);
        check_val("col_last_data", a_rd_data, mem1[8'h13]);
        repeat (6) tick();

        // Strobe in the rd_valid cycle is accepted with no gap
        read_strobe = 1'b1; addr = 8'h20; ram_sel = 1'b0;
        tick();
        read_strobe = 1'b0;
        tick();
        tick();
        check_val("sov_valid", a_rd_valid, 1'b1);
        check_val("sov_data1", a_rd_data, mem1[8'h20]);
        read_strobe = 1'b1; addr = 8'h21; ram_sel = 1'b1;
        tick();
        read_strobe = 1'b0;
        check_val("sov_en2", {a_en1, a_en2}, 2'b01);
        check_val("sov_addr", a_ram_addr, 8'h21);
        tick();
        tick();
        check_val("sov_valid2", a_rd_valid, 1'b1);
        check_val("sov_data2", a_rd_data, mem2[8'h21]);
        repeat (6) tick();

`ifdef RAM_READ_CTRL_OVERRUN_EN
        // Overrun clear without collision, then clear colliding with a strobe while busy
        check_val("ovc_still_set", a_overrun, 1'b1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check_val("ovc_cleared", a_overrun, 1'b0);
        read_strobe = 1'b1; addr = 8'h30; ram_sel = 1'b0;
        tick();
        overrun_clr = 1'b1;
        tick();
        read_strobe = 1'b0; overrun_clr = 1'b0;
        check_val("ovc_set_wins", a_overrun, 1'b1);
        repeat (6) tick();
`endif

        // Reset mid-WAIT on instance b: outputs clear at once and the read is dropped
        read_strobe = 1'b1; addr = 8'h44; ram_sel = 1'b1;
        tick();
        read_strobe = 1'b0;
        tick();
        tick();
        check_val("mrst_busy_before", b_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mrst_addr", b_ram_addr, 8'h00);
        check_val("mrst_en", {b_en1, b_en2}, 2'b00);
        check_val("mrst_data", b_rd_data, 8'h00);
        check_val("mrst_valid_busy", {b_rd_valid, b_busy}, 2'b00);
        vb_base = valid_cnt_b;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check_val("mrst_no_valid", valid_cnt_b - vb_base, 0);
        check_val("mrst_idle", b_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
